// File: rtl/seg_scan_driver.sv
// Multiplexed hex 7-segment scanner with per-digit DP, enable mask, leading-zero blanking,
// 16-level PWM brightness and a frame-synchronous double-buffered load.
module seg_scan_driver #(
   parameter int unsigned DIGITS        = 8,
   parameter int unsigned SCAN_DIV      = 100_000,
   parameter bit          BLANK_LEADING = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [4*DIGITS-1:0]   data_i,
   input  logic [DIGITS-1:0]     dp_i,
   input  logic [DIGITS-1:0]     en_i,
   input  logic                  load_i,
   input  logic [3:0]            bright_i,
   output logic [7:0]            seg_o,
   output logic [DIGITS-1:0]     an_o
);

   localparam int unsigned SlotW = $clog2(SCAN_DIV);
   localparam int unsigned IdxW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [SlotW-1:0]    slot_q, slot_d;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic [4*DIGITS-1:0] shd_data_q, shd_data_d, act_data_q, act_data_d;
   logic [DIGITS-1:0]   shd_dp_q, shd_dp_d, act_dp_q, act_dp_d;
   logic                pend_q, pend_d;
   logic [7:0]          seg_q, seg_d;
   logic [DIGITS-1:0]   an_q, an_d;

   logic                wrap, frame_start, run, cur_dp, cur_blank, cur_en, lit;
   logic [DIGITS-1:0]   blank;
   logic [3:0]          cur_nib;
   logic [7:0]          pat;

   // Scan counters and double-buffered load
   always_comb begin
      wrap        = (slot_q == SlotW'(SCAN_DIV - 1));
      frame_start = wrap && (idx_q == IdxW'(DIGITS - 1));
      slot_d      = wrap ? '0 : slot_q + 1'b1;
      idx_d       = idx_q;
      if (wrap) idx_d = frame_start ? '0 : idx_q + 1'b1;

      shd_data_d = shd_data_q;
      shd_dp_d   = shd_dp_q;
      act_data_d = act_data_q;
      act_dp_d   = act_dp_q;
      pend_d     = pend_q;
      // Frame start copies the old shadow; a coincident load lands in shadow for next frame.
      if (frame_start && pend_q) begin
         act_data_d = shd_data_q;
         act_dp_d   = shd_dp_q;
         pend_d     = 1'b0;
      end
      if (load_i) begin
         shd_data_d = data_i;
         shd_dp_d   = dp_i;
         pend_d     = 1'b1;
      end
   end

   // Leading-zero blanking: a digit blanks while it and everything above it is 0 with no DP
   always_comb begin
      run   = 1'b1;
      blank = '0;
      for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
         run      = run && (act_data_q[4*i +: 4] == 4'h0) && !act_dp_q[i];
         blank[i] = BLANK_LEADING && (i != 0) && run;
      end
   end

   always_comb begin
      cur_nib   = 4'h0;
      cur_dp    = 1'b0;
      cur_blank = 1'b1;
      cur_en    = 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (idx_q == IdxW'(i)) begin
            cur_nib   = act_data_q[4*i +: 4];
            cur_dp    = act_dp_q[i];
            cur_blank = blank[i];
            cur_en    = en_i[i];
         end
      end

      unique case (cur_nib)
         4'h0: pat = 8'hC0;
         4'h1: pat = 8'hF9;
         4'h2: pat = 8'hA4;
         4'h3: pat = 8'hB0;
         4'h4: pat = 8'h99;
         4'h5: pat = 8'h92;
         4'h6: pat = 8'h82;
         4'h7: pat = 8'hF8;
         4'h8: pat = 8'h80;
         4'h9: pat = 8'h98;
         4'hA: pat = 8'h88;
         4'hB: pat = 8'h83;
         4'hC: pat = 8'hC6;
         4'hD: pat = 8'hA1;
         4'hE: pat = 8'h86;
         default: pat = 8'h8E;
      endcase

      lit   = cur_en && !cur_blank && (slot_q[3:0] <= bright_i);
      seg_d = lit ? (pat & ~{cur_dp, 7'b0}) : 8'hFF;
      an_d  = '1;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (lit && (idx_q == IdxW'(i))) an_d[i] = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         slot_q     <= '0;
         idx_q      <= '0;
         shd_data_q <= '0;
         shd_dp_q   <= '0;
         act_data_q <= '0;
         act_dp_q   <= '0;
         pend_q     <= 1'b0;
         seg_q      <= 8'hFF;
         an_q       <= '1;
      end else begin
         slot_q     <= slot_d;
         idx_q      <= idx_d;
         shd_data_q <= shd_data_d;
         shd_dp_q   <= shd_dp_d;
         act_data_q <= act_data_d;
         act_dp_q   <= act_dp_d;
         pend_q     <= pend_d;
         seg_q      <= seg_d;
         an_q       <= an_d;
      end
   end

   assign seg_o = seg_q;
   assign an_o  = an_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver at DIGITS=4, SCAN_DIV=16 (one frame = 64 cycles).
module tb_seg_scan_driver;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic [15:0] data;
   logic [3:0]  dp, en, bright;
   logic        load;
   logic [7:0]  seg;
   logic [3:0]  an;

   int edges  = 0;
   int checks = 0;
   int errors = 0;

   seg_scan_driver #(
      .DIGITS       (4),
      .SCAN_DIV     (16),
      .BLANK_LEADING(1'b1)
   ) dut (
      .clk_i   (clk),
      .rst_ni  (rst_ni),
      .data_i  (data),
      .dp_i    (dp),
      .en_i    (en),
      .load_i  (load),
      .bright_i(bright),
      .seg_o   (seg),
      .an_o    (an)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      edges++;
   endtask

   // Outputs after edge n reflect scan position (n-1) mod 64 = digit*16 + slot.
   task automatic step_to(input int v);
      for (int n = 0; n < 64; n++) begin
         tick();
         if ((edges - 1) % 64 == v) return;
      end
      checks++;
      errors++;
      $display("FAIL step_to: position %0d never reached", v);
   endtask

   task automatic chk(input string tag, input logic [3:0] ea, input logic [7:0] es);
      checks++;
      assert (an === ea && seg === es) else begin
         errors++;
         $error("FAIL %s: an=%b seg=%h expected an=%b seg=%h", tag, an, seg, ea, es);
      end
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] p);
      data = d;
      dp   = p;
      load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   initial begin
      rst_ni = 1'b0;
      data   = '0;
      dp     = '0;
      en     = 4'hF;
      bright = 4'hF;
      load   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset", 4'b1111, 8'hFF);

      // Release with nothing loaded: only digit0 shows 0
      rst_ni = 1'b1;
      edges  = 0;
      step_to(0);  chk("rel_d0", 4'b1110, 8'hC0);
      step_to(16); chk("rel_d1", 4'b1111, 8'hFF);
      step_to(48); chk("rel_d3", 4'b1111, 8'hFF);

      // Load 1A3F mid-frame: not visible until the next frame start
      step_to(4);
      do_load(16'h1A3F, 4'b0000);
      step_to(20); chk("pend_d1", 4'b1111, 8'hFF);
      step_to(63); chk("pend_end", 4'b1111, 8'hFF);
      step_to(0);  chk("1a3f_d0", 4'b1110, 8'h8E);
      step_to(16); chk("1a3f_d1", 4'b1101, 8'hB0);
      step_to(32); chk("1a3f_d2", 4'b1011, 8'h88);
      step_to(48); chk("1a3f_d3", 4'b0111, 8'hF9);

      // Tearing: load during digit1 slot
      step_to(17); chk("tear_d1", 4'b1101, 8'hB0);
      do_load(16'h2222, 4'b0000);
      step_to(32); chk("tear_d2", 4'b1011, 8'h88);
      step_to(48); chk("tear_d3", 4'b0111, 8'hF9);
      step_to(0);  chk("2222_d0", 4'b1110, 8'hA4);
      step_to(16); chk("2222_d1", 4'b1101, 8'hA4);
      step_to(32); chk("2222_d2", 4'b1011, 8'hA4);
      step_to(48); chk("2222_d3", 4'b0111, 8'hA4);

      // Load coincident with frame start: old shadow applies now, new one next frame
      step_to(50);
      do_load(16'h3333, 4'b0000);
      step_to(62);
      do_load(16'h4444, 4'b0000);
      chk("fs_d3", 4'b0111, 8'hA4);
      step_to(0);  chk("3333_d0", 4'b1110, 8'hB0);
      step_to(63); chk("3333_d3", 4'b0111, 8'hB0);
      step_to(0);  chk("4444_d0", 4'b1110, 8'h99);

      // Blanking without DP: digits 2,3 dark
      do_load(16'h0050, 4'b0000);
      step_to(0);  chk("blk_d0", 4'b1110, 8'hC0);
      step_to(16); chk("blk_d1", 4'b1101, 8'h92);
      step_to(32); chk("blk_d2", 4'b1111, 8'hFF);
      step_to(48); chk("blk_d3", 4'b1111, 8'hFF);

      // DP on digit3 keeps it visible
      do_load(16'h0050, 4'b1000);
      step_to(0);  chk("dp_d0", 4'b1110, 8'hC0);
      step_to(16); chk("dp_d1", 4'b1101, 8'h92);
      step_to(48); chk("dp_d3", 4'b0111, 8'h40);

      // Brightness 3: lit for slot cycles 0..3
      bright = 4'd3;
      step_to(0);  chk("br_s0", 4'b1110, 8'hC0);
      step_to(3);  chk("br_s3", 4'b1110, 8'hC0);
      step_to(4);  chk("br_s4", 4'b1111, 8'hFF);
      step_to(15); chk("br_s15", 4'b1111, 8'hFF);

      // Mask digits 1 and 3
      en     = 4'b0101;
      bright = 4'hF;
      step_to(16); chk("en_d1", 4'b1111, 8'hFF);
      step_to(48); chk("en_d3", 4'b1111, 8'hFF);
      step_to(0);  chk("en_d0", 4'b1110, 8'hC0);

      // Asynchronous reset mid-slot with a load pending
      en = 4'hF;
      step_to(5);
      do_load(16'h7777, 4'b0000);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("async_rst", 4'b1111, 8'hFF);
      @(posedge clk);
      #1;
      rst_ni = 1'b1;
      edges  = 0;
      step_to(0);  chk("post_d0", 4'b1110, 8'hC0);
      step_to(16); chk("post_d1", 4'b1111, 8'hFF);
      step_to(0);  chk("post_nopend", 4'b1110, 8'hC0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
